// File: rtl/retrocomm_initiator_tx.sv
// Initiator side of the RetroComm link: sends a 32-bit command as two 16-bit beats,
// then collects a two-beat response, with a response timeout and short-response detection.
module retrocomm_initiator_tx #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Pause,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic [15:0] Dout,
  output logic        Raise,
  input  logic [15:0] Din,
  input  logic        Strobe,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [31:0] r_data,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    StIdle, StSendLo, StSendHi, StWait, StRecvHi, StResp
  } state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e      state;
  logic [15:0] cmd_hi;
  logic [15:0] wait_cnt;

  assign s_ready = (state == StIdle) && !Pause;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= StIdle;
      cmd_hi   <= 16'h0000;
      wait_cnt <= 16'h0000;
      Dout     <= 16'h0000;
      Raise    <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= 32'h0000_0000;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      err      <= 1'b0;
      err_code <= 2'b00;
      case (state)
        StIdle: begin
          if (s_valid && s_ready) begin
            Dout   <= s_data[15:0];
            cmd_hi <= s_data[31:16];
            Raise  <= 1'b1;
            state  <= StSendLo;
          end
        end
        StSendLo: begin
          Dout  <= cmd_hi;
          state <= StSendHi;
        end
        StSendHi: begin
          Raise    <= 1'b0;
          wait_cnt <= 16'h0000;
          state    <= StWait;
        end
        StWait: begin
          // A beat arriving on the last counted cycle wins over the timeout.
          if (Strobe) begin
            r_data[15:0] <= Din;
            state        <= StRecvHi;
          end else if (wait_cnt == CntLast) begin
            err      <= 1'b1;
            err_code <= 2'b01;
            state    <= StIdle;
          end else begin
            wait_cnt <= wait_cnt + 16'h0001;
          end
        end
        StRecvHi: begin
          if (Strobe) begin
            r_data[31:16] <= Din;
            r_valid       <= 1'b1;
            state         <= StResp;
          end else begin
            err      <= 1'b1;
            err_code <= 2'b10;
            r_data   <= 32'h0000_0000;
            state    <= StIdle;
          end
        end
        StResp: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_retrocomm_initiator_tx.sv
// Directed bench for retrocomm_initiator_tx: vector table of transactions plus
// hand sequences for reset, pause, backpressure and mid-transfer reset.
module tb_retrocomm_initiator_tx;

  logic        Clk, Reset, Pause, s_valid, s_ready;
  logic [31:0] s_data;
  logic [15:0] Dout, Din;
  logic        Raise, Strobe, r_valid, r_ready, err;
  logic [31:0] r_data;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  retrocomm_initiator_tx #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset), .Pause(Pause), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .Dout(Dout), .Raise(Raise), .Din(Din), .Strobe(Strobe),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .err(err), .err_code(err_code)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] cmd;
    logic [15:0] lo;
    logic [15:0] hi;
    int          gap;   // Strobe=0 cycles in WAIT before the first beat
    logic [1:0]  code;  // 0 = response, 1 = timeout, 2 = short response
    logic [31:0] exp;
    int          hold;  // cycles r_ready stays low in RESP
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_txn(input vec_t v);
    @(negedge Clk);
    s_valid = 1'b1;
    s_data  = v.cmd;
    chk("s_ready_idle", 32'(s_ready), 32'd1);
    @(negedge Clk);
    s_valid = 1'b0;
    chk("raise_lo", 32'(Raise), 32'd1);
    chk("dout_lo", 32'(Dout), 32'(v.cmd[15:0]));
    chk("s_ready_busy", 32'(s_ready), 32'd0);
    @(negedge Clk);
    chk("raise_hi", 32'(Raise), 32'd1);
    chk("dout_hi", 32'(Dout), 32'(v.cmd[31:16]));
    @(negedge Clk);
    chk("raise_off", 32'(Raise), 32'd0);
    chk("dout_hold", 32'(Dout), 32'(v.cmd[31:16]));
    for (int i = 0; i < v.gap; i++) begin
      Strobe = 1'b0;
      @(negedge Clk);
      if (!(v.code == 2'd1 && i == v.gap - 1)) chk("no_err_wait", 32'(err), 32'd0);
    end
    if (v.code == 2'd1) begin
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_code", 32'(err_code), 32'd1);
      chk("timeout_s_ready", 32'(s_ready), 32'd1);
      chk("timeout_r_valid", 32'(r_valid), 32'd0);
      @(negedge Clk);
      chk("timeout_err_pulse", 32'(err), 32'd0);
    end else begin
      Strobe = 1'b1;
      Din    = v.lo;
      @(negedge Clk);
      chk("beat1_no_err", 32'(err), 32'd0);
      chk("beat1_no_valid", 32'(r_valid), 32'd0);
      if (v.code == 2'd2) begin
        Strobe = 1'b0;
        Din    = 16'h0000;
        @(negedge Clk);
        chk("short_err", 32'(err), 32'd1);
        chk("short_code", 32'(err_code), 32'd2);
        chk("short_r_valid", 32'(r_valid), 32'd0);
        chk("short_discard", r_data, 32'd0);
        @(negedge Clk);
        chk("short_err_pulse", 32'(err), 32'd0);
        chk("short_r_valid2", 32'(r_valid), 32'd0);
      end else begin
        Din = v.hi;
        @(negedge Clk);
        Strobe = 1'b0;
        chk("resp_valid", 32'(r_valid), 32'd1);
        chk("resp_data", r_data, v.exp);
        chk("resp_no_err", 32'(err), 32'd0);
        for (int i = 0; i < v.hold; i++) begin
          // Stray strobes in RESP must not disturb the held response.
          Strobe = 1'b1;
          Din    = 16'hBAD0;
          @(negedge Clk);
          chk("hold_valid", 32'(r_valid), 32'd1);
          chk("hold_data", r_data, v.exp);
          chk("hold_s_ready", 32'(s_ready), 32'd0);
          chk("hold_no_err", 32'(err), 32'd0);
        end
        Strobe  = 1'b0;
        r_ready = 1'b1;
        @(negedge Clk);
        r_ready = 1'b0;
        chk("hs_r_valid", 32'(r_valid), 32'd0);
        chk("hs_s_ready", 32'(s_ready), 32'd1);
      end
    end
  endtask

  initial begin
    vecs[0] = '{32'hDEADBEEF, 16'h5678, 16'h1234, 0, 2'd0, 32'h12345678, 0};
    vecs[1] = '{32'h00000000, 16'hFFFF, 16'h0000, 1, 2'd0, 32'h0000FFFF, 0};
    vecs[2] = '{32'hA5A55A5A, 16'h0001, 16'h8000, 3, 2'd0, 32'h80000001, 0};
    vecs[3] = '{32'h12345678, 16'h0000, 16'h0000, 4, 2'd1, 32'h00000000, 0};
    vecs[4] = '{32'hCAFEF00D, 16'h1111, 16'h2222, 2, 2'd2, 32'h00000000, 0};
    vecs[5] = '{32'hFFFFFFFF, 16'hAAAA, 16'h5555, 0, 2'd0, 32'h5555AAAA, 5};
    vecs[6] = '{32'h0BADCAFE, 16'h4321, 16'h8765, 2, 2'd0, 32'h87654321, 0};

    Reset = 1'b1; Pause = 1'b0; s_valid = 1'b0; s_data = 32'h0;
    Din = 16'h0; Strobe = 1'b0; r_ready = 1'b0;
    #1;
    chk("rst_raise", 32'(Raise), 32'd0);
    chk("rst_dout", 32'(Dout), 32'd0);
    chk("rst_r_valid", 32'(r_valid), 32'd0);
    chk("rst_r_data", r_data, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Pause with s_valid held: nothing is accepted.
    @(negedge Clk);
    Pause   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h11112222;
    for (int i = 0; i < 3; i++) begin
      #1 chk("pause_s_ready", 32'(s_ready), 32'd0);
      @(negedge Clk);
      chk("pause_raise", 32'(Raise), 32'd0);
    end
    Pause   = 1'b0;
    s_valid = 1'b0;

    // Reset while the high beat is on the link.
    @(negedge Clk);
    s_valid = 1'b1;
    s_data  = 32'h76543210;
    @(negedge Clk);
    s_valid = 1'b0;
    @(negedge Clk);
    chk("pre_rst_raise", 32'(Raise), 32'd1);
    chk("pre_rst_dout", 32'(Dout), 32'h7654);
    #1 Reset = 1'b1;
    #1;
    chk("async_rst_raise", 32'(Raise), 32'd0);
    chk("async_rst_dout", 32'(Dout), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);
    @(negedge Clk);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_raise", 32'(Raise), 32'd0);
    run_txn(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
